// File: rtl/step_detector.sv
// rtl/step_detector.sv - pedometer step detector with hysteresis, refractory window and optional SPM estimate (STEP_DETECTOR_SPM_EN)
module step_detector #(
  parameter int DATA_W     = 16,
  parameter int THRESH_HI  = 200,
  parameter int THRESH_LO  = 100,
  parameter int MIN_HIGH   = 4,
  parameter int REFRACT    = 250,
  parameter int CNT_W      = 16,
  parameter int WIN_CYCLES = 1_000_000_000,
  parameter int SPM_MULT   = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              clear,
  input  logic [DATA_W-1:0] sample,
  input  logic              sample_valid,
  output logic              step_pulse,
  output logic [CNT_W-1:0]  step_count,
  output logic [CNT_W-1:0]  spm,
  output logic              spm_valid
);

  typedef enum logic [1:0] {S_IDLE, S_RISE, S_HIGH, S_REFR} state_t;

  localparam logic [DATA_W-1:0] TH_HI   = DATA_W'(THRESH_HI);
  localparam logic [DATA_W-1:0] TH_LO   = DATA_W'(THRESH_LO);
  localparam logic [7:0]        MH      = 8'(MIN_HIGH);
  localparam logic [15:0]       RF      = 16'(REFRACT);
  localparam logic [CNT_W-1:0]  CNT_MAX = '1;

  state_t      state, state_nxt;
  logic [7:0]  hi_cnt, hi_cnt_nxt;
  logic [15:0] ref_cnt, ref_cnt_nxt;
  logic        fire;

  // Next-state logic; the FSM only moves on valid samples and is parked in IDLE while disabled
  always_comb begin
    state_nxt   = state;
    hi_cnt_nxt  = hi_cnt;
    ref_cnt_nxt = ref_cnt;
    fire        = 1'b0;
    if (!en) begin
      state_nxt   = S_IDLE;
      hi_cnt_nxt  = '0;
      ref_cnt_nxt = '0;
    end else if (sample_valid) begin
      case (state)
        S_IDLE: begin
          if (sample >= TH_HI) begin
            hi_cnt_nxt = 8'd1;
            if (MH == 8'd1) begin
              fire      = 1'b1;
              state_nxt = S_HIGH;
            end else begin
              state_nxt = S_RISE;
            end
          end
        end
        S_RISE: begin
          if (sample >= TH_HI) begin
            hi_cnt_nxt = hi_cnt + 8'd1;
            if (hi_cnt + 8'd1 == MH) begin
              fire      = 1'b1;
              state_nxt = S_HIGH;
            end
          end else begin
            hi_cnt_nxt = '0;
            state_nxt  = S_IDLE;
          end
        end
        S_HIGH: begin
          if (sample < TH_LO) begin
            ref_cnt_nxt = RF;
            state_nxt   = S_REFR;
          end
        end
        S_REFR: begin
          // sample value is irrelevant here; each valid sample only burns refractory time
          ref_cnt_nxt = ref_cnt - 16'd1;
          if (ref_cnt <= 16'd1) begin
            ref_cnt_nxt = '0;
            state_nxt   = S_IDLE;
          end
        end
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  // State, pulse and saturating step counter; clear overrides a coincident step
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      hi_cnt     <= '0;
      ref_cnt    <= '0;
      step_pulse <= 1'b0;
      step_count <= '0;
    end else begin
      state      <= state_nxt;
      hi_cnt     <= hi_cnt_nxt;
      ref_cnt    <= ref_cnt_nxt;
      step_pulse <= fire;
      if (clear)
        step_count <= '0;
      else if (fire && step_count != CNT_MAX)
        step_count <= step_count + CNT_W'(1);
    end
  end

`ifdef STEP_DETECTOR_SPM_EN
  localparam int              TW       = $clog2(WIN_CYCLES) + 1;
  localparam int              PW       = CNT_W + 32;
  localparam logic [TW-1:0]   WIN_LAST = TW'(WIN_CYCLES - 1);

  logic [TW-1:0]    win_timer;
  logic [CNT_W-1:0] win_steps;
  logic [PW-1:0]    spm_prod;
  logic             win_wrap;

  assign win_wrap = (win_timer == WIN_LAST);
  assign spm_prod = PW'(win_steps) * PW'(SPM_MULT);

  // Free-running window; on wrap publish the scaled step count and restart the tally
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      win_timer <= '0;
      win_steps <= '0;
      spm       <= '0;
      spm_valid <= 1'b0;
    end else begin
      win_timer <= win_wrap ? '0 : win_timer + TW'(1);
      if (win_wrap) begin
        spm       <= (spm_prod > PW'(CNT_MAX)) ? CNT_MAX : spm_prod[CNT_W-1:0];
        spm_valid <= 1'b1;
        win_steps <= fire ? CNT_W'(1) : '0;
      end else if (fire && win_steps != CNT_MAX) begin
        win_steps <= win_steps + CNT_W'(1);
      end
    end
  end
`else
  assign spm       = '0;
  assign spm_valid = 1'b0;
`endif

endmodule
